// File: rtl/rpn_controle.sv
// rtl/rpn_controle.sv - operand entry, execute and write-back sequencer for the 2-level RPN stack
// Button edges become single-cycle push strobes; EXEC writes the ALU result back into the stack top.
module rpn_controle #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         btn_enter,
   input  logic         btn_op,
   input  logic [W-1:0] chaves,
   input  logic [2:0]   op_sel,
   input  logic [W-1:0] alu_res,
   output logic [W-1:0] dado_pilha,
   output logic         habilitaA,
   output logic         habilitaB,
   output logic [2:0]   op_ula,
   output logic [1:0]   estado,
   output logic [W-1:0] resultado,
   output logic         resultado_valido,
   output logic         erro
);

   typedef enum logic [1:0] {
      VAZIO = 2'b00,
      UM    = 2'b01,
      DOIS  = 2'b10,
      EXEC  = 2'b11
   } state_t;

   state_t         state_q;
   logic           enter_q;
   logic           op_q;
   logic [2:0]     op_ula_q;
   logic [W-1:0]   resultado_q;
   logic           valido_q;
   logic           erro_q;

   logic           ent;
   logic           opr;

   assign ent = btn_enter & ~enter_q;
   assign opr = btn_op & ~op_q;

   // Strobes are decoded from the current state so the stack captures in the same cycle as the press.
   assign habilitaA  = rst & (((state_q == VAZIO) & ent & ~opr) | (state_q == EXEC));
   assign habilitaB  = rst & (state_q == UM) & ent & ~opr;
   assign dado_pilha = (state_q == EXEC) ? alu_res : chaves;

   assign op_ula           = op_ula_q;
   assign estado           = state_q;
   assign resultado        = resultado_q;
   assign resultado_valido = valido_q;
   assign erro             = erro_q;

   always_ff @(posedge clk) begin
      // Button history tracks through reset so a press held across release yields no edge.
      enter_q <= btn_enter;
      op_q    <= btn_op;
      if (!rst) begin
         state_q     <= VAZIO;
         op_ula_q    <= 3'b000;
         resultado_q <= '0;
         valido_q    <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         valido_q <= 1'b0;
         erro_q   <= 1'b0;
         case (state_q)
            VAZIO: begin
               if (opr)      erro_q  <= 1'b1;
               else if (ent) state_q <= UM;
            end
            UM: begin
               if (opr)      erro_q  <= 1'b1;
               else if (ent) state_q <= DOIS;
            end
            DOIS: begin
               if (ent) begin
                  erro_q <= 1'b1;
               end else if (opr) begin
                  op_ula_q <= op_sel;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               resultado_q <= alu_res;
               valido_q    <= 1'b1;
               state_q     <= UM;
            end
            default: state_q <= VAZIO;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_controle.sv
// tb/tb_rpn_controle.sv - vector table plus result scoreboard for rpn_controle
// Includes a 2-entry stack and small ALU model fed by the DUT strobes.
module tb_rpn_controle;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_enter;
   logic       btn_op;
   logic [7:0] chaves;
   logic [2:0] op_sel;
   logic [7:0] alu_res;
   logic [7:0] dado_pilha;
   logic       habilitaA;
   logic       habilitaB;
   logic [2:0] op_ula;
   logic [1:0] estado;
   logic [7:0] resultado;
   logic       resultado_valido;
   logic       erro;

   logic [7:0] stk_top;
   logic [7:0] stk_bot;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic       rst, en, op;
      logic [7:0] ch;
      logic [2:0] sel;
      logic [1:0] est;
      logic       ha, hb, err, val;
      logic [7:0] dado;
      logic       sb;
      logic [7:0] res;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb_q[$];

   rpn_controle #(.W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .btn_enter        (btn_enter),
      .btn_op           (btn_op),
      .chaves           (chaves),
      .op_sel           (op_sel),
      .alu_res          (alu_res),
      .dado_pilha       (dado_pilha),
      .habilitaA        (habilitaA),
      .habilitaB        (habilitaB),
      .op_ula           (op_ula),
      .estado           (estado),
      .resultado        (resultado),
      .resultado_valido (resultado_valido),
      .erro             (erro)
   );

   always #5 clk = ~clk;

   // A = bottom, B = top; habilitaB shifts top down before loading.
   always @(posedge clk) begin
      if (habilitaB) begin
         stk_bot <= stk_top;
         stk_top <= dado_pilha;
      end else if (habilitaA) begin
         stk_top <= dado_pilha;
      end
   end

   always_comb begin
      case (op_ula)
         3'd1:    alu_res = stk_bot - stk_top;
         3'd2:    alu_res = stk_bot & stk_top;
         3'd3:    alu_res = stk_bot | stk_top;
         default: alu_res = stk_bot + stk_top;
      endcase
   end

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %0h, want %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic o, input logic [7:0] c, input logic [2:0] s,
                      input logic [1:0] es, input logic a, input logic b, input logic er, input logic vl,
                      input logic [7:0] d, input logic sbp, input logic [7:0] rs);
      vec_t v;
      v.rst = r; v.en = e; v.op = o; v.ch = c; v.sel = s;
      v.est = es; v.ha = a; v.hb = b; v.err = er; v.val = vl;
      v.dado = d; v.sb = sbp; v.res = rs;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic e, input logic o, input logic [7:0] c, input logic [2:0] s);
      @(negedge clk);
      rst = r; btn_enter = e; btn_op = o; chaves = c; op_sel = s;
      #1;
   endtask

   task automatic check_sb(input int row);
      if (resultado_valido) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", row, 32'd1, 32'd0);
         end else begin
            chk("resultado", row, {24'd0, resultado}, {24'd0, sb_q.pop_front()});
         end
      end
   endtask

   initial begin
      int n_ha;
      rst = 1'b0; btn_enter = 1'b1; btn_op = 1'b0; chaves = 8'h00; op_sel = 3'd0;

      //   rst en op ch     sel  est ha hb er vl dado   sb res
      add(0, 1, 0, 8'h00, 3'd0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      add(1, 1, 0, 8'h00, 3'd0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      add(1, 0, 0, 8'h00, 3'd0, 2'd0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      add(1, 1, 0, 8'h12, 3'd0, 2'd0, 1, 0, 0, 0, 8'h12, 0, 8'h00);
      add(1, 1, 0, 8'h34, 3'd0, 2'd1, 0, 0, 0, 0, 8'h34, 0, 8'h00);
      add(1, 0, 0, 8'h34, 3'd0, 2'd1, 0, 0, 0, 0, 8'h34, 0, 8'h00);
      add(1, 1, 0, 8'h34, 3'd0, 2'd1, 0, 1, 0, 0, 8'h34, 0, 8'h00);
      add(1, 0, 0, 8'h34, 3'd0, 2'd2, 0, 0, 0, 0, 8'h34, 0, 8'h00);
      add(1, 0, 1, 8'h34, 3'd0, 2'd2, 0, 0, 0, 0, 8'h34, 1, 8'h46);
      add(1, 0, 1, 8'h34, 3'd0, 2'd3, 1, 0, 0, 0, 8'h46, 0, 8'h00);
      add(1, 0, 0, 8'h34, 3'd0, 2'd1, 0, 0, 0, 1, 8'h34, 0, 8'h00);
      add(1, 1, 0, 8'h05, 3'd0, 2'd1, 0, 1, 0, 0, 8'h05, 0, 8'h00);
      add(1, 0, 0, 8'h05, 3'd0, 2'd2, 0, 0, 0, 0, 8'h05, 0, 8'h00);
      add(1, 0, 1, 8'h05, 3'd1, 2'd2, 0, 0, 0, 0, 8'h05, 1, 8'h41);
      add(1, 0, 0, 8'h05, 3'd1, 2'd3, 1, 0, 0, 0, 8'h41, 0, 8'h00);
      add(1, 0, 0, 8'h05, 3'd1, 2'd1, 0, 0, 0, 1, 8'h05, 0, 8'h00);
      add(1, 1, 1, 8'h05, 3'd1, 2'd1, 0, 0, 0, 0, 8'h05, 0, 8'h00);
      add(1, 0, 0, 8'h05, 3'd1, 2'd1, 0, 0, 1, 0, 8'h05, 0, 8'h00);
      add(1, 0, 1, 8'h05, 3'd1, 2'd1, 0, 0, 0, 0, 8'h05, 0, 8'h00);
      add(1, 0, 0, 8'h05, 3'd1, 2'd1, 0, 0, 1, 0, 8'h05, 0, 8'h00);
      add(1, 1, 0, 8'h07, 3'd1, 2'd1, 0, 1, 0, 0, 8'h07, 0, 8'h00);
      add(1, 0, 0, 8'h07, 3'd1, 2'd2, 0, 0, 0, 0, 8'h07, 0, 8'h00);
      add(1, 1, 0, 8'h07, 3'd1, 2'd2, 0, 0, 0, 0, 8'h07, 0, 8'h00);
      add(1, 0, 0, 8'h07, 3'd1, 2'd2, 0, 0, 1, 0, 8'h07, 0, 8'h00);
      add(0, 0, 0, 8'h07, 3'd1, 2'd2, 0, 0, 0, 0, 8'h07, 0, 8'h00);
      add(1, 0, 1, 8'h07, 3'd1, 2'd0, 0, 0, 0, 0, 8'h07, 0, 8'h00);
      add(1, 0, 0, 8'h07, 3'd1, 2'd0, 0, 0, 1, 0, 8'h07, 0, 8'h00);
      add(1, 0, 0, 8'h07, 3'd1, 2'd0, 0, 0, 0, 0, 8'h07, 0, 8'h00);

      // First reset edge: outputs are undefined until it has been taken.
      @(negedge clk);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].ch, vecs[i].sel);
         chk("estado",     i, {30'd0, estado}, {30'd0, vecs[i].est});
         chk("habilitaA",  i, {31'd0, habilitaA}, {31'd0, vecs[i].ha});
         chk("habilitaB",  i, {31'd0, habilitaB}, {31'd0, vecs[i].hb});
         chk("erro",       i, {31'd0, erro}, {31'd0, vecs[i].err});
         chk("valido",     i, {31'd0, resultado_valido}, {31'd0, vecs[i].val});
         chk("dado_pilha", i, {24'd0, dado_pilha}, {24'd0, vecs[i].dado});
         if (habilitaA && habilitaB) chk("strobe_excl", i, 32'd1, 32'd0);
         if (i == 7) chk("stack_AB", i, {16'd0, stk_bot, stk_top}, 32'h1234);
         if (i == 27) chk("resultado_reset", i, {24'd0, resultado}, 32'd0);
         check_sb(i);
         if (vecs[i].sb) sb_q.push_back(vecs[i].res);
      end

      // Held enter for 20 cycles in VAZIO gives a single push.
      n_ha = 0;
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 1'b1, 1'b0, 8'h21, 3'd0);
         if (habilitaA) n_ha++;
      end
      chk("hold_single_push", 100, n_ha, 1);
      drive(1'b1, 1'b0, 1'b0, 8'h21, 3'd0);
      chk("hold_estado", 101, {30'd0, estado}, 32'd1);

      // Reset asserted during EXEC suppresses the write-back.
      drive(1'b1, 1'b1, 1'b0, 8'h09, 3'd0);
      chk("pre_exec_hb", 102, {31'd0, habilitaB}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 8'h09, 3'd0);
      drive(1'b1, 1'b0, 1'b1, 8'h09, 3'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h09, 3'd0);
      chk("exec_estado", 103, {30'd0, estado}, 32'd3);
      chk("exec_rst_ha", 103, {31'd0, habilitaA}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h09, 3'd0);
      chk("post_rst_estado", 104, {30'd0, estado}, 32'd0);
      chk("post_rst_resultado", 104, {24'd0, resultado}, 32'd0);
      chk("post_rst_valido", 104, {31'd0, resultado_valido}, 32'd0);
      chk("post_rst_op_ula", 104, {29'd0, op_ula}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h09, 3'd0);
      chk("post_rst_valido2", 105, {31'd0, resultado_valido}, 32'd0);
      chk("post_rst_erro", 105, {31'd0, erro}, 32'd0);

      chk("scoreboard_drained", 106, sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
